// File: rtl/csi_rx_lane_ctrl.sv
// D-PHY RX lane sequencer: detects LP-11 -> LP-01 -> LP-00 SoT on all lanes and gates the HS capture window.
// Optional LP glitch filter enabled by defining CSI_RX_LP_FILTER_EN.
module csi_rx_lane_ctrl #(
    parameter int LANES      = 2,
    parameter int T_INIT     = 100,
    parameter int T_SETTLE   = 8,
    parameter int T_RQST_MAX = 64,
    parameter int T_HS_MAX   = 0,
    parameter int LP_FILT    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [LANES-1:0] LP_P,
    input  logic [LANES-1:0] LP_N,
    output logic             HS_TERM_EN,
    output logic             HS_RX_EN,
    output logic             ALIGN_RST,
    output logic             BURST_DONE,
    output logic             ERR_SOT,
    output logic             ERR_HS_TO,
    output logic [15:0]      BURST_CNT,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_STOP    = 3'd1,
        S_HS_RQST = 3'd2,
        S_SETTLE  = 3'd3,
        S_HS_RX   = 3'd4
    } state_t;

    // Aggregate LP code: {mixed, P, N}
    localparam logic [2:0] C_LP11 = 3'b011;
    localparam logic [2:0] C_LP10 = 3'b010;
    localparam logic [2:0] C_LP01 = 3'b001;
    localparam logic [2:0] C_LP00 = 3'b000;
    localparam logic [2:0] C_MIX  = 3'b100;

    localparam int             CW          = 16;
    localparam logic [CW-1:0]  INIT_LAST   = CW'(T_INIT - 1);
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(T_SETTLE - 1);
    localparam logic [CW-1:0]  SOT_LAST    = CW'(T_RQST_MAX - 1);
    localparam logic [CW-1:0]  HS_LAST     = CW'((T_HS_MAX > 0) ? T_HS_MAX - 1 : 0);

    logic [LANES-1:0] r_p1, r_p2, r_n1, r_n2;
    logic [2:0]       w_code;
    logic [2:0]       w_lp;

    state_t           r_state, w_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_sot;
    logic [1:0]       r_bad;
    logic             w_sot_to, w_hs_to;
    logic             w_err_sot, w_err_hs, w_done;
    logic             r_done, r_err_sot, r_err_hs;
    logic [15:0]      r_burst_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_p1 <= '1;
            r_p2 <= '1;
            r_n1 <= '1;
            r_n2 <= '1;
        end else begin
            r_p1 <= LP_P;
            r_p2 <= r_p1;
            r_n1 <= LP_N;
            r_n2 <= r_n1;
        end
    end

    always_comb begin
        w_code = C_MIX;
        if ((&r_p2 || ~|r_p2) && (&r_n2 || ~|r_n2))
            w_code = {1'b0, r_p2[0], r_n2[0]};
    end

`ifdef CSI_RX_LP_FILTER_EN
    localparam int FW = $clog2(LP_FILT + 1);

    logic [2:0]    r_cand, r_filt;
    logic [FW-1:0] r_stab;
    logic          w_stable;

    // A new code reaches the FSM only after LP_FILT identical samples in a row.
    assign w_stable = (LP_FILT <= 1) || ((w_code == r_cand) && (r_stab >= FW'(LP_FILT - 1)));
    assign w_lp     = w_stable ? w_code : r_filt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cand <= C_LP11;
            r_filt <= C_LP11;
            r_stab <= '0;
        end else begin
            r_cand <= w_code;
            r_filt <= w_lp;
            if (w_code != r_cand)
                r_stab <= FW'(1);
            else if (r_stab < FW'(LP_FILT - 1))
                r_stab <= r_stab + 1'b1;
        end
    end
`else
    assign w_lp = w_code;
`endif

    assign w_sot_to = (r_sot >= SOT_LAST);
    assign w_hs_to  = (T_HS_MAX != 0) && (r_cnt >= HS_LAST);

    always_comb begin
        w_nxt     = r_state;
        w_err_sot = 1'b0;
        w_err_hs  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (w_lp == C_LP11 && r_cnt >= INIT_LAST)
                    w_nxt = S_STOP;
            end
            S_STOP: begin
                // LP-10, LP-00 or MIXED is tolerated for 2 cycles to absorb lane skew.
                if (w_lp == C_LP01) begin
                    w_nxt = S_HS_RQST;
                end else if (w_lp != C_LP11 && r_bad >= 2'd2) begin
                    w_nxt     = S_INIT;
                    w_err_sot = 1'b1;
                end
            end
            S_HS_RQST: begin
                if (w_sot_to || w_lp == C_LP10) begin
                    w_nxt     = S_INIT;
                    w_err_sot = 1'b1;
                end else if (w_lp == C_LP00) begin
                    w_nxt = S_SETTLE;
                end else if (w_lp == C_LP11) begin
                    w_nxt = S_STOP;
                end
            end
            S_SETTLE: begin
                if (w_sot_to) begin
                    w_nxt     = S_INIT;
                    w_err_sot = 1'b1;
                end else if (r_cnt >= SETTLE_LAST) begin
                    w_nxt = S_HS_RX;
                end
            end
            S_HS_RX: begin
                if (w_hs_to) begin
                    w_nxt    = S_INIT;
                    w_err_hs = 1'b1;
                end else if (w_lp == C_LP11) begin
                    w_nxt  = S_STOP;
                    w_done = 1'b1;
                end
            end
            default: w_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_sot       <= '0;
            r_bad       <= '0;
            r_done      <= 1'b0;
            r_err_sot   <= 1'b0;
            r_err_hs    <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state   <= w_nxt;
            r_done    <= w_done;
            r_err_sot <= w_err_sot;
            r_err_hs  <= w_err_hs;

            // Shared per-state counter: restarts on every state change.
            if (w_nxt != r_state || (r_state == S_INIT && w_lp != C_LP11))
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;

            // SoT timer spans HS_RQST and SETTLE without restarting.
            if ((r_state == S_HS_RQST || r_state == S_SETTLE) &&
                (w_nxt == S_HS_RQST || w_nxt == S_SETTLE)) begin
                if (r_sot != '1)
                    r_sot <= r_sot + 1'b1;
            end else begin
                r_sot <= '0;
            end

            if (r_state == S_STOP && w_nxt == S_STOP && w_lp != C_LP11) begin
                if (r_bad != 2'd3)
                    r_bad <= r_bad + 1'b1;
            end else begin
                r_bad <= '0;
            end

            if (w_done)
                r_burst_cnt <= r_burst_cnt + 16'd1;
        end
    end

    assign STATE      = r_state;
    assign HS_TERM_EN = (r_state == S_SETTLE) || (r_state == S_HS_RX);
    assign HS_RX_EN   = (r_state == S_HS_RX);
    assign ALIGN_RST  = (r_state != S_HS_RX);
    assign BURST_DONE = r_done;
    assign ERR_SOT    = r_err_sot;
    assign ERR_HS_TO  = r_err_hs;
    assign BURST_CNT  = r_burst_cnt;

endmodule

// File: tb/tb_csi_rx_lane_ctrl.sv
// Directed bench for csi_rx_lane_ctrl: default instance plus one with T_HS_MAX=50.
module tb_csi_rx_lane_ctrl;

    logic       CLK;
    logic       RST;
    logic [1:0] LP_P, LP_N;

    logic        d_term, d_rxen, d_arst, d_done, d_esot, d_eto;
    logic [15:0] d_cnt;
    logic [2:0]  d_state;
    logic        h_term, h_rxen, h_arst, h_done, h_esot, h_eto;
    logic [15:0] h_cnt;
    logic [2:0]  h_state;

    int   total;
    int   bad;
    logic mon_err;

    csi_rx_lane_ctrl u_dut (
        .CLK(CLK), .RST(RST), .LP_P(LP_P), .LP_N(LP_N),
        .HS_TERM_EN(d_term), .HS_RX_EN(d_rxen), .ALIGN_RST(d_arst),
        .BURST_DONE(d_done), .ERR_SOT(d_esot), .ERR_HS_TO(d_eto),
        .BURST_CNT(d_cnt), .STATE(d_state)
    );

    csi_rx_lane_ctrl #(.T_HS_MAX(50)) u_hto (
        .CLK(CLK), .RST(RST), .LP_P(LP_P), .LP_N(LP_N),
        .HS_TERM_EN(h_term), .HS_RX_EN(h_rxen), .ALIGN_RST(h_arst),
        .BURST_DONE(h_done), .ERR_SOT(h_esot), .ERR_HS_TO(h_eto),
        .BURST_CNT(h_cnt), .STATE(h_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic tick_mon(input int n);
        repeat (n) begin
            @(negedge CLK);
            if (d_esot || d_eto) mon_err = 1'b1;
        end
    endtask

    task automatic set_lp(input logic p, input logic n);
        LP_P = {2{p}};
        LP_N = {2{n}};
    endtask

    task automatic test_reset;
        RST = 1'b1;
        set_lp(1'b1, 1'b1);
        tick(2);
        total++; if (d_state !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", d_state); end
        total++; if (d_term !== 1'b0 || d_rxen !== 1'b0) begin bad++; $display("FAIL rst_hs: got term=%b rxen=%b want 0 0", d_term, d_rxen); end
        total++; if (d_arst !== 1'b1) begin bad++; $display("FAIL rst_align: got %b want 1", d_arst); end
        total++; if (d_done !== 1'b0 || d_esot !== 1'b0 || d_eto !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %b%b%b want 000", d_done, d_esot, d_eto); end
        total++; if (d_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", d_cnt); end
        RST = 1'b0;
        tick(99);
        total++; if (d_state !== 3'd0) begin bad++; $display("FAIL init_99: got %0d want 0", d_state); end
        tick(1);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL init_100: got %0d want 1", d_state); end
        total++; if (d_term !== 1'b0 || d_arst !== 1'b1) begin bad++; $display("FAIL stop_outs: got term=%b arst=%b want 0 1", d_term, d_arst); end
    endtask

    task automatic test_normal_burst;
        set_lp(1'b0, 1'b1);
        tick(2);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL nb_lat2: got %0d want 1", d_state); end
        tick(1);
        total++; if (d_state !== 3'd2) begin bad++; $display("FAIL nb_rqst: got %0d want 2", d_state); end
        tick(7);
        set_lp(1'b0, 1'b0);
        tick(2);
        total++; if (d_state !== 3'd2 || d_term !== 1'b0) begin bad++; $display("FAIL nb_pre_settle: got st=%0d term=%b want 2 0", d_state, d_term); end
        tick(1);
        total++; if (d_state !== 3'd3 || d_term !== 1'b1 || d_rxen !== 1'b0) begin bad++; $display("FAIL nb_settle: got st=%0d term=%b rxen=%b want 3 1 0", d_state, d_term, d_rxen); end
        tick(7);
        total++; if (d_rxen !== 1'b0) begin bad++; $display("FAIL nb_settle_end: got rxen=%b want 0", d_rxen); end
        tick(1);
        total++; if (d_state !== 3'd4 || d_rxen !== 1'b1 || d_arst !== 1'b0 || d_term !== 1'b1) begin bad++; $display("FAIL nb_hsrx: got st=%0d rxen=%b arst=%b term=%b want 4 1 0 1", d_state, d_rxen, d_arst, d_term); end
        tick(9);
        set_lp(1'b1, 1'b1);
        tick(2);
        total++; if (d_state !== 3'd4 || d_done !== 1'b0) begin bad++; $display("FAIL nb_pre_end: got st=%0d done=%b want 4 0", d_state, d_done); end
        tick(1);
        total++; if (d_state !== 3'd1 || d_done !== 1'b1 || d_cnt !== 16'd1 || d_arst !== 1'b1 || d_rxen !== 1'b0) begin bad++; $display("FAIL nb_end: got st=%0d done=%b cnt=%0d arst=%b rxen=%b want 1 1 1 1 0", d_state, d_done, d_cnt, d_arst, d_rxen); end
        tick(1);
        total++; if (d_done !== 1'b0 || d_cnt !== 16'd1) begin bad++; $display("FAIL nb_done_pulse: got done=%b cnt=%0d want 0 1", d_done, d_cnt); end
    endtask

    task automatic test_sot_timeout;
        set_lp(1'b0, 1'b1);
        tick(3);
        total++; if (d_state !== 3'd2) begin bad++; $display("FAIL sot_rqst: got %0d want 2", d_state); end
        tick(63);
        total++; if (d_state !== 3'd2 || d_esot !== 1'b0) begin bad++; $display("FAIL sot_63: got st=%0d esot=%b want 2 0", d_state, d_esot); end
        tick(1);
        total++; if (d_state !== 3'd0 || d_esot !== 1'b1 || d_term !== 1'b0) begin bad++; $display("FAIL sot_64: got st=%0d esot=%b term=%b want 0 1 0", d_state, d_esot, d_term); end
        tick(1);
        total++; if (d_esot !== 1'b0) begin bad++; $display("FAIL sot_pulse: got %b want 0", d_esot); end
        tick(2);
        set_lp(1'b1, 1'b1);
        tick(101);
        total++; if (d_state !== 3'd0) begin bad++; $display("FAIL sot_reinit_early: got %0d want 0", d_state); end
        tick(1);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL sot_reinit: got %0d want 1", d_state); end
    endtask

    task automatic test_lane_skew;
        mon_err = 1'b0;
        LP_P = 2'b10; LP_N = 2'b11;
        tick_mon(1);
        LP_P = 2'b00;
        tick_mon(2);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL skew_stop: got %0d want 1", d_state); end
        tick_mon(1);
        total++; if (d_state !== 3'd2) begin bad++; $display("FAIL skew_rqst: got %0d want 2", d_state); end
        tick_mon(6);
        LP_N = 2'b10;
        tick_mon(1);
        LP_N = 2'b00;
        tick_mon(2);
        total++; if (d_state !== 3'd2) begin bad++; $display("FAIL skew_mixed_rqst: got %0d want 2", d_state); end
        tick_mon(1);
        total++; if (d_state !== 3'd3) begin bad++; $display("FAIL skew_settle: got %0d want 3", d_state); end
        tick_mon(8);
        total++; if (d_state !== 3'd4) begin bad++; $display("FAIL skew_hsrx: got %0d want 4", d_state); end
        tick_mon(8);
        LP_P = 2'b01; LP_N = 2'b01;
        tick_mon(1);
        LP_P = 2'b11; LP_N = 2'b11;
        tick_mon(2);
        total++; if (d_state !== 3'd4) begin bad++; $display("FAIL skew_mixed_hs: got %0d want 4", d_state); end
        tick_mon(1);
        total++; if (d_state !== 3'd1 || d_done !== 1'b1 || d_cnt !== 16'd2) begin bad++; $display("FAIL skew_end: got st=%0d done=%b cnt=%0d want 1 1 2", d_state, d_done, d_cnt); end
        total++; if (mon_err !== 1'b0) begin bad++; $display("FAIL skew_no_err: got %b want 0", mon_err); end
    endtask

    task automatic test_lp10;
        set_lp(1'b1, 1'b0);
        tick(4);
        total++; if (d_state !== 3'd1 || d_esot !== 1'b0) begin bad++; $display("FAIL lp10_hold: got st=%0d esot=%b want 1 0", d_state, d_esot); end
        tick(1);
        total++; if (d_state !== 3'd0 || d_esot !== 1'b1) begin bad++; $display("FAIL lp10_err: got st=%0d esot=%b want 0 1", d_state, d_esot); end
        set_lp(1'b1, 1'b1);
        tick(101);
        total++; if (d_state !== 3'd0) begin bad++; $display("FAIL lp10_reinit_early: got %0d want 0", d_state); end
        tick(1);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL lp10_reinit: got %0d want 1", d_state); end
    endtask

    task automatic test_hs_timeout;
        set_lp(1'b0, 1'b1);
        tick(10);
        set_lp(1'b0, 1'b0);
        tick(11);
        total++; if (d_state !== 3'd4 || h_state !== 3'd4) begin bad++; $display("FAIL hto_enter: got d=%0d h=%0d want 4 4", d_state, h_state); end
        tick(49);
        total++; if (h_state !== 3'd4 || h_eto !== 1'b0) begin bad++; $display("FAIL hto_49: got st=%0d eto=%b want 4 0", h_state, h_eto); end
        tick(1);
        total++; if (h_state !== 3'd0 || h_eto !== 1'b1 || h_rxen !== 1'b0 || h_term !== 1'b0) begin bad++; $display("FAIL hto_50: got st=%0d eto=%b rxen=%b term=%b want 0 1 0 0", h_state, h_eto, h_rxen, h_term); end
        total++; if (h_cnt !== 16'd2 || h_done !== 1'b0) begin bad++; $display("FAIL hto_cnt: got cnt=%0d done=%b want 2 0", h_cnt, h_done); end
        total++; if (d_state !== 3'd4 || d_eto !== 1'b0) begin bad++; $display("FAIL hto_disabled: got st=%0d eto=%b want 4 0", d_state, d_eto); end
        tick(1);
        total++; if (h_eto !== 1'b0) begin bad++; $display("FAIL hto_pulse: got %b want 0", h_eto); end
        tick(8);
        total++; if (d_rxen !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got rxen=%b want 1", d_rxen); end
        #1 RST = 1'b1;
        #1;
        total++; if (d_rxen !== 1'b0 || d_term !== 1'b0 || d_arst !== 1'b1 || d_state !== 3'd0 || d_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid: got rxen=%b term=%b arst=%b st=%0d cnt=%0d want 0 0 1 0 0", d_rxen, d_term, d_arst, d_state, d_cnt); end
        set_lp(1'b1, 1'b1);
        tick(2);
        RST = 1'b0;
        tick(100);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL rst_mid_reinit: got %0d want 1", d_state); end
    endtask

    task automatic test_glitch;
        logic [2:0] exp_mid;
`ifdef CSI_RX_LP_FILTER_EN
        exp_mid = 3'd1;
`else
        exp_mid = 3'd2;
`endif
        mon_err = 1'b0;
        set_lp(1'b0, 1'b1);
        tick_mon(2);
        set_lp(1'b1, 1'b1);
        tick_mon(1);
        total++; if (d_state !== exp_mid) begin bad++; $display("FAIL glitch_mid: got %0d want %0d", d_state, exp_mid); end
        tick_mon(2);
        total++; if (d_state !== 3'd1) begin bad++; $display("FAIL glitch_back: got %0d want 1", d_state); end
        tick_mon(6);
        total++; if (d_state !== 3'd1 || mon_err !== 1'b0) begin bad++; $display("FAIL glitch_settled: got st=%0d err=%b want 1 0", d_state, mon_err); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        mon_err = 1'b0;
        RST     = 1'b1;
        LP_P    = 2'b11;
        LP_N    = 2'b11;
        test_reset;
        test_normal_burst;
        test_sot_timeout;
        test_lane_skew;
        test_lp10;
        test_hs_timeout;
        test_glitch;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
